// File: rtl/stream_write_buffer.sv
// Stream-to-SDRAM write buffer: FIFO of stream words drained as
// fixed-length write bursts at sequential word addresses.
module stream_write_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BURST_LEN  = 8,
  parameter int ADDR_W     = 22
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  wr_req,
  input  logic                  wr_ack,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [31:0]           wr_data,
  input  logic                  wr_data_en,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [31:0]           words_written
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int LVL_W  = DEPTH_LOG2 + 1;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;

  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BURST
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           ww_q, ww_d;
  logic                  req_q, req_d;

  logic full;
  logic pop;
  logic push;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  always_comb begin
    full = (level_q == LVL_FULL);
    pop  = (state_q == S_BURST) && wr_data_en;
    push = in_valid && (!full || pop);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    ww_d     = ww_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      ww_d     = ww_q + 32'd1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (in_valid && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (level_q >= LVL_BURST) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (wr_ack) begin
          state_d = S_BURST;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        if (pop) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = S_IDLE;
            addr_d  = addr_q + ADDR_STEP;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      ovf_q    <= 1'b0;
      ww_q     <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
      ww_q     <= ww_d;
      req_q    <= req_d;
    end
  end

  // Storage is not reset; stale contents are never read after a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  assign wr_req        = req_q;
  assign wr_addr       = addr_q;
  assign wr_data       = mem[rd_ptr_q];
  assign level         = level_q;
  assign overflow      = ovf_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_stream_write_buffer.sv
// Randomized bench for stream_write_buffer against a queue-based
// reference model of the FIFO and burst protocol.
module tb_stream_write_buffer;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          wr_req;
  logic          wr_ack;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_data_en;
  logic [4:0]    level;
  logic          overflow;
  logic [31:0]   words_written;

  int checks = 0;
  int errors = 0;

  logic [31:0]   m_q[$];
  logic [31:0]   popped[$];
  int            m_phase;
  int            m_beats;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_ww;
  bit            m_ovf;

  always #5 clk = ~clk;

  stream_write_buffer #(
    .DEPTH_LOG2(4),
    .BURST_LEN (8),
    .ADDR_W    (AW)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .wr_req       (wr_req),
    .wr_ack       (wr_ack),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_data_en   (wr_data_en),
    .level        (level),
    .overflow     (overflow),
    .words_written(words_written)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_q.delete();
    popped.delete();
    m_phase = 0;
    m_beats = 0;
    m_addr  = '0;
    m_ww    = '0;
    m_ovf   = 1'b0;
  endtask

  // phase: 0 waiting for a burst's worth, 1 requesting, 2 bursting
  task automatic tick();
    int lvl0;
    bit pop;
    lvl0 = m_q.size();
    pop  = (m_phase == 2) && wr_data_en;
    if (pop) begin
      popped.push_back(m_q.pop_front());
      m_ww++;
    end
    if (in_valid) begin
      if (lvl0 < 16 || pop) m_q.push_back(in_data);
      else m_ovf = 1'b1;
    end
    case (m_phase)
      0: if (lvl0 >= 8) m_phase = 1;
      1: if (wr_ack) begin m_phase = 2; m_beats = 0; end
      default: if (pop) begin
        m_beats++;
        if (m_beats == 8) begin
          m_phase = 0;
          m_addr += 4'd8;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_data    = '0;
    wr_ack     = 1'b0;
    wr_data_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      in_valid   = 1'($urandom);
      in_data    = $urandom;
      wr_ack     = 1'($urandom);
      wr_data_en = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (wr_req !== 1'b0 || overflow !== 1'b0 || wr_addr !== '0 ||
          level !== '0 || words_written !== '0) begin
        errors++;
        $display("FAIL reset_hold req=%b ovf=%b addr=%0d lvl=%0d ww=%0d want all 0",
                 wr_req, overflow, wr_addr, level, words_written);
      end
    end
    idle_inputs();
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      in_valid = 1'b1;
      in_data  = i;
      tick();
      in_valid = 1'b0;
      checks++;
      if (level !== 5'(i + 1)) begin
        errors++;
        $display("FAIL reset_level got %0d want %0d", level, i + 1);
      end
      checks++;
      if (wr_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_noreq after push %0d got %b want 0", i, wr_req);
      end
    end
    tick();
    checks++;
    if (wr_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_rise got %b want 1", wr_req);
    end
  endtask

  task automatic test_basic();
    int n = 0;
    int age = 0;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid = (cyc % 18 == 0) && (n < 8);
      in_data  = n;
      if (in_valid) n++;
      wr_ack     = (m_phase == 1) && (age == 3);
      age        = (m_phase == 1) ? age + 1 : 0;
      wr_data_en = 1'b1;
      checks++;
      if (level !== 5'(m_q.size()) || wr_req !== (m_phase == 1)) begin
        errors++;
        $display("FAIL basic_cycle lvl=%0d req=%b want lvl=%0d req=%b",
                 level, wr_req, m_q.size(), m_phase == 1);
      end
      if (m_phase == 2) begin
        checks++;
        if (wr_data !== m_q[0] || wr_addr !== 4'd0) begin
          errors++;
          $display("FAIL basic_data got %0d@%0d want %0d@0",
                   wr_data, wr_addr, m_q[0]);
        end
      end
      tick();
      if (popped.size() == 8 && m_phase == 0) break;
    end
    checks++;
    if (popped.size() != 8) begin
      errors++;
      $display("FAIL basic_timeout popped %0d want 8", popped.size());
    end
    for (int i = 0; i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== 32'(i)) begin
        errors++;
        $display("FAIL basic_seq[%0d] got %0d want %0d", i, popped[i], i);
      end
    end
    checks++;
    if (wr_addr !== 4'd8 || words_written !== 32'd8 || level !== 5'd0) begin
      errors++;
      $display("FAIL basic_end addr=%0d ww=%0d lvl=%0d want 8 8 0",
               wr_addr, words_written, level);
    end
  endtask

  task automatic test_push_pop();
    int n = 0;
    int both = 0;
    int lvl_before;
    bit coincide;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid   = (cyc % 2 == 0) && (n < 16);
      in_data    = n;
      if (in_valid) n++;
      wr_ack     = (m_phase == 1) && ($urandom_range(0, 2) == 0);
      wr_data_en = 1'b1;
      coincide   = in_valid && (m_phase == 2);
      lvl_before = m_q.size();
      checks++;
      if (level !== 5'(m_q.size())) begin
        errors++;
        $display("FAIL pushpop_level got %0d want %0d", level, m_q.size());
      end
      if (m_phase == 2) begin
        checks++;
        if (wr_data !== m_q[0]) begin
          errors++;
          $display("FAIL pushpop_data got %0d want %0d", wr_data, m_q[0]);
        end
      end
      tick();
      if (coincide) begin
        both++;
        checks++;
        if (level !== 5'(lvl_before)) begin
          errors++;
          $display("FAIL pushpop_same got %0d want %0d", level, lvl_before);
        end
      end
      if (popped.size() == 16 && m_phase == 0) break;
    end
    checks++;
    if (popped.size() != 16 || both == 0) begin
      errors++;
      $display("FAIL pushpop_timeout popped %0d coincide %0d want 16 >0",
               popped.size(), both);
    end
    for (int i = 0; i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== 32'(i)) begin
        errors++;
        $display("FAIL pushpop_seq[%0d] got %0d want %0d", i, popped[i], i);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid   = 1'b1;
      in_data    = i;
      wr_data_en = 1'($urandom);
      tick();
    end
    idle_inputs();
    checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || wr_req !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full lvl=%0d ovf=%b req=%b want 16 1 1",
               level, overflow, wr_req);
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      wr_ack     = (m_phase == 1) && ($urandom_range(0, 3) == 0);
      wr_data_en = 1'($urandom);
      checks++;
      if (level !== 5'(m_q.size()) || wr_req !== (m_phase == 1) ||
          overflow !== 1'b1) begin
        errors++;
        $display("FAIL ovf_cycle lvl=%0d req=%b ovf=%b want %0d %b 1",
                 level, wr_req, overflow, m_q.size(), m_phase == 1);
      end
      if (m_phase == 2 && wr_data_en) begin
        checks++;
        if (wr_data !== m_q[0]) begin
          errors++;
          $display("FAIL ovf_data got %0d want %0d", wr_data, m_q[0]);
        end
      end
      tick();
      if (popped.size() == 16 && m_phase == 0) break;
    end
    checks++;
    if (popped.size() != 16) begin
      errors++;
      $display("FAIL ovf_timeout popped %0d want 16", popped.size());
    end
    for (int i = 0; i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== 32'(i)) begin
        errors++;
        $display("FAIL ovf_seq[%0d] got %0d want %0d", i, popped[i], i);
      end
    end
    checks++;
    if (overflow !== 1'b1 || level !== 5'd0 || words_written !== 32'd16) begin
      errors++;
      $display("FAIL ovf_end ovf=%b lvl=%0d ww=%0d want 1 0 16",
               overflow, level, words_written);
    end
  endtask

  task automatic test_stall_wrap();
    logic [31:0] sent[$];
    logic [AW-1:0] exp_addr;
    int gap = 0;
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      in_valid = 1'b0;
      if (gap == 0 && sent.size() < 24) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        sent.push_back(in_data);
        gap = $urandom_range(3, 4);
      end else if (gap > 0) begin
        gap--;
      end
      wr_ack     = ($urandom_range(0, 3) == 0);
      wr_data_en = cyc[0];
      exp_addr   = AW'((popped.size() / 8) * 8);
      checks++;
      if (wr_addr !== exp_addr || level !== 5'(m_q.size()) ||
          wr_req !== (m_phase == 1)) begin
        errors++;
        $display("FAIL wrap_cycle addr=%0d lvl=%0d req=%b want %0d %0d %b",
                 wr_addr, level, wr_req, exp_addr, m_q.size(), m_phase == 1);
      end
      if (m_phase == 2 && wr_data_en) begin
        checks++;
        if (wr_data !== m_q[0]) begin
          errors++;
          $display("FAIL wrap_data got %h want %h", wr_data, m_q[0]);
        end
      end
      tick();
      if (popped.size() == 24 && m_phase == 0) break;
    end
    checks++;
    if (popped.size() != 24) begin
      errors++;
      $display("FAIL wrap_timeout popped %0d want 24", popped.size());
    end
    for (int i = 0; i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== sent[i]) begin
        errors++;
        $display("FAIL wrap_seq[%0d] got %h want %h", i, popped[i], sent[i]);
      end
    end
    checks++;
    if (overflow !== 1'b0 || words_written !== 32'd24 || wr_addr !== 4'd8) begin
      errors++;
      $display("FAIL wrap_end ovf=%b ww=%0d addr=%0d want 0 24 8",
               overflow, words_written, wr_addr);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    for (int cyc = 0; cyc < 100; cyc++) begin
      in_valid   = (n < 8);
      in_data    = 50 + n;
      if (in_valid) n++;
      wr_ack     = (m_phase == 1);
      wr_data_en = 1'b1;
      tick();
      if (popped.size() == 3) break;
    end
    checks++;
    if (words_written !== 32'd3) begin
      errors++;
      $display("FAIL mid_pre ww=%0d want 3", words_written);
    end
    #1;
    n_rst = 1'b0;
    #1;
    checks++;
    if (wr_req !== 1'b0 || wr_addr !== '0 || level !== '0 ||
        overflow !== 1'b0 || words_written !== '0) begin
      errors++;
      $display("FAIL mid_async req=%b addr=%0d lvl=%0d ovf=%b ww=%0d want 0",
               wr_req, wr_addr, level, overflow, words_written);
    end
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      in_valid   = (n < 8);
      in_data    = 100 + n;
      if (in_valid) n++;
      wr_ack     = (m_phase == 1) && ($urandom_range(0, 1) == 0);
      wr_data_en = 1'($urandom);
      checks++;
      if (level !== 5'(m_q.size()) || wr_addr !== m_addr ||
          wr_req !== (m_phase == 1)) begin
        errors++;
        $display("FAIL mid_cycle lvl=%0d addr=%0d req=%b want %0d %0d %b",
                 level, wr_addr, wr_req, m_q.size(), m_addr, m_phase == 1);
      end
      tick();
      if (popped.size() == 8 && m_phase == 0) break;
    end
    checks++;
    if (popped.size() != 8) begin
      errors++;
      $display("FAIL mid_timeout popped %0d want 8", popped.size());
    end
    for (int i = 0; i < popped.size(); i++) begin
      checks++;
      if (popped[i] !== 32'(100 + i)) begin
        errors++;
        $display("FAIL mid_seq[%0d] got %0d want %0d", i, popped[i], 100 + i);
      end
    end
    checks++;
    if (words_written !== 32'd8 || wr_addr !== 4'd8) begin
      errors++;
      $display("FAIL mid_end ww=%0d addr=%0d want 8 8", words_written, wr_addr);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_push_pop();
    test_overflow();
    test_stall_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_write_buffer.md
# stream_write_buffer

Sits directly downstream of the 32-bit stream generator and upstream of the SDRAM controller write port. Accepts single-cycle-strobed stream words into an internal FIFO. When a full burst is available, requests the controller, then supplies exactly BURST_LEN words at sequential SDRAM word addresses. Reports FIFO level, total words written and a sticky overflow flag for the stream test.

## Interface
- DEPTH_LOG2, default 4: FIFO depth is 2^DEPTH_LOG2 words (16).
- BURST_LEN, default 8: words per SDRAM write burst; power of two, ≤ 2^DEPTH_LOG2.
- ADDR_W, default 22: width of the SDRAM word address.

- clk  in  1  clock; all logic on rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- in_data  in  32  stream word.
- in_valid  in  1  one-cycle strobe; in_data is pushed when high.
- wr_req  out  1  burst request to the controller.
- wr_ack  in  1  controller grant; one-cycle pulse.
- wr_addr  out  ADDR_W  start word address of the current or pending burst.
- wr_data  out  32  FIFO head word; valid while in BURST.
- wr_data_en  in  1  controller takes wr_data this cycle.
- level  out  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2.
- overflow  out  1  sticky: a word was dropped.
- words_written  out  32  count of words handed to the controller; wraps modulo 2^32.

## Operation
- FIFO is a circular buffer with read/write pointers and a separate occupancy counter. wr_data is the show-ahead head word (combinational from memory at the read pointer).
- Push: in_valid=1 and (level < depth, or a pop occurs in the same cycle) → write word, advance write pointer.
- Push with in_valid=1 while level == depth and no pop that cycle → word dropped, overflow set to 1 until reset.
- Pop: state == BURST and wr_data_en=1 → advance read pointer, words_written += 1.
- wr_data_en outside BURST is ignored.
- Simultaneous push and pop: level unchanged, both pointers advance.
- FSM:
  - IDLE: if level ≥ BURST_LEN → REQ.
  - REQ: wr_req=1. On wr_ack=1 → BURST and clear the beat counter.
  - BURST: wr_req=0. Beat counter increments on each pop. On the pop that brings the beat count to BURST_LEN → IDLE, and wr_addr += BURST_LEN (wraps modulo 2^ADDR_W).
- wr_ack outside REQ is ignored.
- FIFO cannot underflow in BURST: entry requires level ≥ BURST_LEN, and only this burst pops.
- The controller may stall by deasserting wr_data_en mid-burst. BURST persists until BURST_LEN pops have occurred; there is no timeout.

## Timing
- Reset values: wr_req=0, wr_addr=0, level=0, overflow=0, words_written=0, FSM=IDLE, pointers=0. wr_data is don't-care.
- Reset is asynchronous, takes effect immediately and may land in any state, including mid-burst. FIFO contents are discarded.
- in_valid high at edge N → level reflects the push after edge N (visible in cycle N+1).
- Request latency: wr_req (registered) rises one cycle after level first shows ≥ BURST_LEN.
- wr_req falls the cycle after the edge that samples wr_ack=1.
- wr_data is valid in the first BURST cycle. The controller may assert wr_data_en from that cycle on.
- Back-to-back bursts: after the last pop, one IDLE cycle, then REQ if level ≥ BURST_LEN. Minimum 2 cycles between the last pop and the next wr_req.
- wr_addr updates on the edge of the final pop and stays stable from REQ through BURST.
- Throughput: at the generator rate of one word per 18 clocks, one burst per 144 clocks. The FIFO absorbs up to 8 words of controller grant latency beyond the burst itself.

## Test plan
- Reset: hold n_rst=0 with random inputs → all outputs at reset values. Release → wr_req stays 0 until 8 words are pushed.
- Basic burst: push 0..7 every 18 cycles; wr_ack 3 cycles after wr_req; wr_data_en held high → wr_data sequence is 0..7 with wr_addr=0. Afterwards wr_addr=8, words_written=8, level=0.
- Push during pop: pushes 0..9, burst in progress, word 10 pushed in the same cycle as a pop → level exact at every cycle. Second burst (started after 16 words) delivers 8..15.
- Overflow: 17 pushes (values 0..16) with wr_ack withheld → level=16, overflow=1, word 16 dropped. Subsequent bursts deliver 0..7, then 8..15. overflow stays 1.
- Stall and wrap: ADDR_W=4, wr_data_en toggling 1/0 → three bursts at wr_addr 0, 8, 0. Data is contiguous, no duplicated or skipped words. wr_ack pulses outside REQ are ignored.
- Reset mid-burst: assert n_rst after 3 pops → immediate reset values. A new 8-word stream then bursts from address 0.
